my_ram_512_arbiter: RTL and testbench

MY_RAM_512_ARBITER -- requirements
Module: my_ram_512_arbiter

---
 rtl/my_ram_512_arbiter.sv | 145 ++++++++++++++
 tb/tb_my_ram_512_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/my_ram_512_arbiter.sv
// Two-port arbiter in front of a single-port RAM with a zero-fill engine.
// The RAM is external: this block drives address/data/write strobe and
// samples the combinational read data when an access completes. A clear
// walks every address writing zero; requests are held off while it runs.
module my_ram_512_arbiter #(
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 16,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    // port 0
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    // port 1
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    // clear control
    input  logic              clear,
    output logic              busy,
    // RAM side
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                last_gnt_q, last_gnt_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;

    logic                elig0, elig1;
    logic                gnt0, gnt1;

    // A port whose ack is currently high has already been served for the
    // request it is still holding, so it sits out this cycle.
    assign elig0 = req0 & ~ack0_q;
    assign elig1 = req1 & ~ack1_q;

    // Next-state, grant selection and RAM drive.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        ram_addr   = addr0;
        ram_in     = wdata0;
        ram_load   = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                ram_addr  = clr_cnt_q;
                ram_in    = '0;
                ram_load  = 1'b1;
                // counter wraps to zero naturally after the last address
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else begin
                    // on a tie, last_gnt_q == 1 hands the slot to port 0
                    gnt0 = elig0 & (~elig1 | last_gnt_q);
                    gnt1 = elig1 & ~gnt0;
                    if (gnt1) begin
                        ram_addr = addr1;
                        ram_in   = wdata1;
                        ram_load = we1;
                    end else if (gnt0) begin
                        ram_load = we0;
                    end
                end
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    // Completion side: ack pulse, read capture and fairness bookkeeping.
    always_comb begin
        ack0_d     = gnt0;
        ack1_d     = gnt1;
        rdata0_d   = (gnt0 & ~we0) ? ram_out : rdata0_q;
        rdata1_d   = (gnt1 & ~we1) ? ram_out : rdata1_q;
        last_gnt_d = last_gnt_q;
        if (gnt0) begin
            last_gnt_d = 1'b0;
        end else if (gnt1) begin
            last_gnt_d = 1'b1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RST_STATE;
            clr_cnt_q  <= '0;
            last_gnt_q <= 1'b1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            last_gnt_q <= last_gnt_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign busy   = (state_q == ST_CLEAR);
    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_my_ram_512_arbiter.sv
// Directed bench for my_ram_512_arbiter with a behavioural 512x16 RAM.
module tb_my_ram_512_arbiter;

    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, we0, req1, we1, clear;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, busy, ram_load;
    logic [DW-1:0] rdata0, rdata1, ram_in, ram_out;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] mem [0:511];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    my_ram_512_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1),
        .clear(clear), .busy(busy),
        .ram_addr(ram_addr), .ram_in(ram_in), .ram_load(ram_load),
        .ram_out(ram_out)
    );

    // behavioural RAM: combinational read, write on the clock edge
    assign ram_out = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_load) mem[ram_addr] <= ram_in;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_ack0"}, ack0, 0);
        check_val({tag, "_ack1"}, ack1, 0);
        check_val({tag, "_rdata0"}, rdata0, 0);
        check_val({tag, "_rdata1"}, rdata1, 0);
        check_val({tag, "_busy"}, busy, 1);
        check_val({tag, "_addr"}, ram_addr, 0);
        check_val({tag, "_load"}, ram_load, 1);
    endtask

    // full clear sequence starting in the current cycle; clear pulse at cnt pulse_at
    task automatic check_clear_walk(input string tag, input int pulse_at);
        for (int k = 0; k < 512; k++) begin
            check_val({tag, "_busy"}, busy, 1);
            check_val({tag, "_addr"}, ram_addr, k);
            check_val({tag, "_load"}, ram_load, 1);
            check_val({tag, "_in"}, ram_in, 0);
            check_val({tag, "_ack1"}, ack1, 0);
            clear = (k == pulse_at);
            tick();
        end
        clear = 1'b0;
        check_val({tag, "_done"}, busy, 0);
    endtask

    // single access on port p, run from an idle, uncontended cycle
    task automatic port_access(input int p, input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
        if (p == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
        end
        #1;
        check_val("gnt_addr", ram_addr, a);
        check_val("gnt_load", ram_load, we);
        if (we) check_val("gnt_wdata", ram_in, wd);
        tick();
        check_val("ack_hi", (p == 0) ? ack0 : ack1, 1);
        check_val("ack_other", (p == 0) ? ack1 : ack0, 0);
        if (!we) check_val("rdata", (p == 0) ? rdata0 : rdata1, exp_rd);
        $display("port%0d %s addr=%0d data=0x%04h", p, we ? "WR" : "RD", a,
                 we ? wd : ((p == 0) ? rdata0 : rdata1));
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        tick();
        check_val("ack_lo", (p == 0) ? ack0 : ack1, 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'hDEAD;
        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        clear = 0;

        // reset state and power-up clear
        tick();
        tick();
        check_reset_vals("rst");
        reset = 1'b0;
        #1;
        check_clear_walk("init_clr", -1);

        // cleared RAM reads back as zero
        port_access(0, 1'b0, 9'd300, 16'h0, 16'h0000);

        // write/read on both ports, read data holds across writes
        port_access(0, 1'b1, 9'd5, 16'h1234, 16'h0);
        port_access(0, 1'b0, 9'd5, 16'h0, 16'h1234);
        port_access(1, 1'b1, 9'd511, 16'hBEEF, 16'h0);
        port_access(1, 1'b0, 9'd511, 16'h0, 16'hBEEF);
        port_access(0, 1'b1, 9'd6, 16'h5555, 16'h0);
        check_val("rdata0_hold", rdata0, 16'h1234);
        port_access(1, 1'b0, 9'd6, 16'h0, 16'h5555);

        // contention: both held, port 1 served last so port 0 leads
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 9'd5; addr1 = 9'd511;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) req0 = 1'b0;
            #1;
            check_val("alt_addr", ram_addr, (i % 2 == 0) ? 5 : 511);
            check_val("alt_load", ram_load, 0);
            check_val("alt_ack0", ack0, (i % 2 == 1) ? 1 : 0);
            check_val("alt_ack1", ack1, (i > 0 && i % 2 == 0) ? 1 : 0);
            $display("contend cycle %0d granted port%0d", i, i % 2);
            tick();
        end
        check_val("alt_end_ack1", ack1, 1);
        check_val("alt_end_ack0", ack0, 0);
        check_val("alt_rdata0", rdata0, 16'h1234);
        check_val("alt_rdata1", rdata1, 16'hBEEF);
        req1 = 1'b0;
        tick();
        check_val("alt_idle_ack0", ack0, 0);
        check_val("alt_idle_ack1", ack1, 0);

        // clear in IDLE with port 1 pending; second clear pulse at cnt 100 ignored
        addr0 = 9'd3;
        clear = 1; req1 = 1; we1 = 0; addr1 = 9'd511;
        #1;
        check_val("clr_nogrant_load", ram_load, 0);
        check_val("clr_nogrant_addr", ram_addr, 3);
        check_val("clr_nogrant_busy", busy, 0);
        tick();
        clear = 0;
        check_clear_walk("clr2", 100);
        check_val("post_clr_gnt_addr", ram_addr, 511);
        check_val("post_clr_ack1", ack1, 0);
        tick();
        check_val("post_clr_ack1_hi", ack1, 1);
        check_val("post_clr_rdata1", rdata1, 0);
        $display("port1 RD addr=511 data=0x%04h after clear", rdata1);
        req1 = 0;
        tick();

        // give rdata0 a non-zero value and make port 0 the last winner
        port_access(0, 1'b1, 9'd7, 16'h00A5, 16'h0);
        port_access(0, 1'b0, 9'd7, 16'h0, 16'h00A5);

        // reset in the middle of a clear
        clear = 1;
        tick();
        clear = 0;
        for (int k = 0; k < 200; k++) tick();
        check_val("pre_rst_addr", ram_addr, 200);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_clear_walk("rst_clr", -1);

        // first tie after reset goes to port 0
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 9'd7; addr1 = 9'd8;
        #1;
        check_val("tie_first_addr", ram_addr, 7);
        tick();
        check_val("tie_ack0", ack0, 1);
        check_val("tie_ack1", ack1, 0);
        check_val("tie_rdata0", rdata0, 0);
        req0 = 0;
        #1;
        check_val("tie_second_addr", ram_addr, 8);
        tick();
        check_val("tie_ack1_hi", ack1, 1);
        req1 = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
